// File: rtl/sweep_scheduler_if.sv
// Sampler handshake bundle between the sweep scheduler (master) and the sampler (slave).
interface sweep_scheduler_if;
  logic        request_run;
  logic [31:0] signal_select;
  logic [31:0] total_cycles;
  logic        running;
  logic        result_ready;
  logic [31:0] result;

  modport master (
    output request_run, signal_select, total_cycles,
    input  running, result_ready, result
  );

  modport slave (
    input  request_run, signal_select, total_cycles,
    output running, result_ready, result
  );
endinterface

// File: rtl/sweep_scheduler.sv
// Steps the sampler through a range of signal selects and buffers one result per point.
// Define SWEEP_TIMEOUT_EN to enable the handshake watchdog (TIMEOUT_CYCLES).
//
// state       | meaning
// IDLE        | waiting for start
// ISSUE       | raise run request for the current select
// WAIT_ACK    | hold request until sampler reports running
// WAIT_RESULT | wait for result strobe, write buffer
// STORE       | bump count, pick next select or finish
// FINISH      | one-cycle done pulse
module sweep_scheduler #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           first_select,
  input  logic [31:0]           last_select,
  input  logic [31:0]           cycles_per_point,
  sweep_scheduler_if.master     sampler,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   point_count,
  output logic [1:0]            status
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RESULT, S_STORE, S_FINISH
  } state_t;

`ifdef SWEEP_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [DEPTH_LOG2:0] FULL_COUNT   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] COUNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [31:0]         TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [31:0] select_q;
  logic [31:0] last_q;
  logic [31:0] total_q;
  logic        request_q;
  logic [1:0]  status_q;
  logic [31:0] timer_q;
  logic        timeout_hit;
  logic        last_hit;
  logic [DEPTH_LOG2:0] count_inc;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign sampler.request_run   = request_q;
  assign sampler.signal_select = select_q;
  assign sampler.total_cycles  = total_q;
  assign status                = status_q;

  assign last_hit    = (select_q == last_q);
  assign count_inc   = point_count + COUNT_ONE;
  // Terminal count of the watchdog down-counter; constant 0 when the watchdog is compiled out.
  assign timeout_hit = TIMEOUT_ON && (timer_q == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start) state_d = (first_select > last_select) ? S_FINISH : S_ISSUE;
      S_ISSUE:
        state_d = S_WAIT_ACK;
      S_WAIT_ACK:
        if (sampler.running)  state_d = S_WAIT_RESULT;
        else if (timeout_hit) state_d = S_FINISH;
      S_WAIT_RESULT:
        if (sampler.result_ready) state_d = S_STORE;
        else if (timeout_hit)     state_d = S_FINISH;
      S_STORE:
        state_d = (last_hit || count_inc == FULL_COUNT) ? S_FINISH : S_ISSUE;
      S_FINISH:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select_q    <= 32'd0;
      last_q      <= 32'd0;
      total_q     <= 32'd0;
      request_q   <= 1'b0;
      point_count <= '0;
      status_q    <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE:
          if (start) begin
            select_q    <= first_select;
            last_q      <= last_select;
            total_q     <= cycles_per_point;
            point_count <= '0;
            status_q    <= 2'b00;
          end
        S_ISSUE:
          request_q <= 1'b1;
        S_WAIT_ACK:
          if (sampler.running) begin
            request_q <= 1'b0;
          end else if (timeout_hit) begin
            request_q   <= 1'b0;
            status_q[1] <= 1'b1;
          end
        S_WAIT_RESULT:
          if (!sampler.result_ready && timeout_hit) status_q[1] <= 1'b1;
        S_STORE: begin
          point_count <= count_inc;
          // Equality with last is tested before incrementing, so 32'hFFFFFFFF never wraps.
          if (!last_hit) begin
            if (count_inc == FULL_COUNT) status_q[0] <= 1'b1;
            else                         select_q    <= select_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          timer_q <= 32'd0;
    else if (state_q == S_ISSUE)        timer_q <= TIMEOUT_LOAD;
    else if ((state_q == S_WAIT_ACK || state_q == S_WAIT_RESULT) && timer_q != 32'd0)
                                        timer_q <= timer_q - 32'd1;
  end

  // Buffer is never cleared; the write is gated by reset so a strobe in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_WAIT_RESULT && sampler.result_ready)
      mem[point_count[DEPTH_LOG2-1:0]] <= sampler.result;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a behavioural sampler returning select+4 per point.
module tb_sweep_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] first_select, last_select, cycles_per_point;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [4:0]  point_count;
  logic [1:0]  status;

  int errors = 0;
  int checks = 0;

  // 0 silent, 1 full response, 2 acknowledge only
  int          smp_mode = 0;
  logic [31:0] sel_q[$];
  logic [31:0] max_sel;
  int          done_cnt;
  int          req_hi;

  sweep_scheduler_if sif();

  sweep_scheduler #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_select     (first_select),
    .last_select      (last_select),
    .cycles_per_point (cycles_per_point),
    .sampler          (sif.master),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .busy             (busy),
    .done             (done),
    .point_count      (point_count),
    .status           (status)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    if (smp_mode != 0 && sif.request_run && !sif.running) begin
      sif.running = 1'b1;
      sel_q.push_back(sif.signal_select);
      if (sif.signal_select > max_sel) max_sel = sif.signal_select;
      if (smp_mode == 1) begin
        repeat (3) @(negedge clk);
        sif.running      = 1'b0;
        sif.result       = sif.signal_select + 32'd4;
        sif.result_ready = 1'b1;
        @(negedge clk);
        sif.result_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sif.request_run) req_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    sel_q.delete();
    max_sel  = 32'd0;
    done_cnt = 0;
    req_hi   = 0;
  endtask

  // Returns at the negedge after the start edge.
  task automatic start_sweep(input logic [31:0] f, input logic [31:0] l, input logic [31:0] c);
    @(negedge clk);
    first_select     = f;
    last_select      = l;
    cycles_per_point = c;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (!done && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [31:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    reset = 1'b1; start = 1'b0; rd_addr = '0;
    first_select = '0; last_select = '0; cycles_per_point = '0;
    sif.running = 1'b0; sif.result_ready = 1'b0; sif.result = '0;
    clear_log();
    repeat (3) @(negedge clk);

    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_count",  {27'd0, point_count}, 32'd0);
    check("rst_status", {30'd0, status}, 32'd0);
    check("rst_req",    {31'd0, sif.request_run}, 32'd0);
    check("rst_sel",    sif.signal_select, 32'd0);
    check("rst_total",  sif.total_cycles, 32'd0);
    reset = 1'b0;

    // three-point sweep with start latency probe
    smp_mode = 1; clear_log();
    start_sweep(32'd3, 32'd5, 32'd10);
    check("lat_req_c1", {31'd0, sif.request_run}, 32'd0);
    check("lat_busy",   {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_req_c2", {31'd0, sif.request_run}, 32'd1);
    check("total_cyc",  sif.total_cycles, 32'd10);
    wait_done("s3", 200, cyc);
    check("s3_count",  {27'd0, point_count}, 32'd3);
    check("s3_status", {30'd0, status}, 32'd0);
    @(negedge clk);
    check("s3_done_1cyc", {31'd0, done}, 32'd0);
    check("s3_done_cnt",  done_cnt, 32'd1);
    check("s3_nsel",      sel_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("s3_sel", (i < sel_q.size()) ? sel_q[i] : 32'hFFFF_FFFF, 32'd3 + 32'(i));
      read_buf(4'(i), rd);
      check("s3_buf", rd, 32'd7 + 32'(i));
    end

    // start while busy and a stray result strobe during ISSUE
    clear_log();
    start_sweep(32'd3, 32'd4, 32'd1);
    start = 1'b1; first_select = 32'd100; last_select = 32'd200;
    sif.result = 32'hDEAD; sif.result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; sif.result_ready = 1'b0;
    wait_done("sp", 200, cyc);
    check("sp_count", {27'd0, point_count}, 32'd2);
    check("sp_nsel",  sel_q.size(), 32'd2);
    check("sp_maxsel", max_sel, 32'd4);
    read_buf(4'd0, rd); check("sp_buf0", rd, 32'd7);
    read_buf(4'd1, rd); check("sp_buf1", rd, 32'd8);
    @(negedge clk);

    // truncation at buffer depth
    clear_log();
    start_sweep(32'd0, 32'd20, 32'd5);
    wait_done("tr", 1000, cyc);
    check("tr_count",  {27'd0, point_count}, 32'd16);
    check("tr_status", {30'd0, status}, 32'd1);
    check("tr_maxsel", max_sel, 32'd15);
    check("tr_nsel",   sel_q.size(), 32'd16);
    @(negedge clk);
    check("tr_done_cnt", done_cnt, 32'd1);
    read_buf(4'd0,  rd); check("tr_buf0",  rd, 32'd4);
    read_buf(4'd15, rd); check("tr_buf15", rd, 32'd19);

    // empty range
    clear_log();
    start_sweep(32'd9, 32'd2, 32'd5);
    check("em_done_c1", {31'd0, done}, 32'd1);
    check("em_count",   {27'd0, point_count}, 32'd0);
    repeat (3) @(negedge clk);
    check("em_req_hi",   req_hi, 32'd0);
    check("em_done_cnt", done_cnt, 32'd1);
    check("em_busy",     {31'd0, busy}, 32'd0);

    // reset while waiting for the result
    smp_mode = 2; clear_log();
    start_sweep(32'd3, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    check("rw_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; sif.running = 1'b0; smp_mode = 0;
    sif.result = 32'h0BAD; sif.result_ready = 1'b1;
    @(negedge clk);
    sif.result_ready = 1'b0;
    @(negedge clk);
    check("rw_busy",  {31'd0, busy}, 32'd0);
    check("rw_count", {27'd0, point_count}, 32'd0);
    check("rw_req",   {31'd0, sif.request_run}, 32'd0);
    check("rw_sel",   sif.signal_select, 32'd0);
    read_buf(4'd0, rd); check("rw_buf0", rd, 32'd4);

    // single point at the top of the select range
    smp_mode = 1; clear_log();
    start_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    wait_done("top", 200, cyc);
    check("top_count", {27'd0, point_count}, 32'd1);
    check("top_sel",   sif.signal_select, 32'hFFFF_FFFF);
    check("top_nsel",  sel_q.size(), 32'd1);
    read_buf(4'd0, rd); check("top_buf0", rd, 32'd3);

`ifdef SWEEP_TIMEOUT_EN
    smp_mode = 0; clear_log();
    @(negedge clk);
    start_sweep(32'd1, 32'd1, 32'd1);
    cyc = 1;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("to_cycles", cyc, 32'd102);
    check("to_status", {30'd0, status}, 32'd2);
    check("to_req",    {31'd0, sif.request_run}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
